// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and ABI register indices for the register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 1;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_T0   = 5;
  localparam int unsigned REG_T1   = 6;
  localparam int unsigned REG_T2   = 7;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A1   = 11;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits. When a set and a clear hit the same
// register on the same edge, the set wins because a newer producer owns it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic [NREAD*AW-1:0] lookup_addr,
  output logic [NREAD-1:0]    lookup_busy
);

  logic [NREGS-1:0] busy;

  // Busy-bit update; the set is issued after the clear so it takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  // Combinational lookup for each read port.
  always_comb begin
    lookup_busy = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      lookup_busy[k] = busy[lookup_addr[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: clear-after-reset engine, gated write port with
// optional bypass to the read ports, pending-write scoreboard and debug read.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NREAD    = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  output logic                  ready,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  if (NREGS < 2 || (1 << AW) != NREGS) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two and at least 2");
  end

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_valid;
  logic            iss_valid;
  logic [NREAD-1:0] sb_busy;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  // Next state, ready and the gated write/issue strobes.
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    wr_valid  = 1'b0;
    iss_valid = 1'b0;
    case (state)
      ST_INIT: if (clr_cnt == AW'(NREGS - 1)) state_nx = ST_RUN;
      ST_RUN: begin
        ready     = 1'b1;
        wr_valid  = wr_en && !(ZERO_REG && wr_addr == '0);
        iss_valid = issue_en && !(ZERO_REG && issue_addr == '0);
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // Clear counter walks every entry once while in INIT.
  always_ff @(posedge clock) begin
    if (reset)                 clr_cnt <= '0;
    else if (state == ST_INIT) clr_cnt <= clr_cnt + AW'(1);
  end

  // Array write: the clear engine owns the array in INIT, the write port in RUN.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) regs[clr_cnt] <= '0;
    else if (wr_valid)    regs[wr_addr] <= wr_data;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .set_en      (iss_valid),
    .set_addr    (issue_addr),
    .clr_en      (wr_valid),
    .clr_addr    (wr_addr),
    .lookup_addr (rd_addr),
    .lookup_busy (sb_busy)
  );

  // Read ports: hardwired zero, then same-cycle bypass, then the array.
  always_comb begin
    logic [AW-1:0] ra;
    logic          fwd;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra  = rd_addr[k*AW +: AW];
      fwd = BYPASS && wr_valid && (wr_addr == ra);
      if (ready && !(ZERO_REG && ra == '0)) begin
        rd_data[k*XLEN +: XLEN] = fwd ? wr_data : regs[ra];
        rd_busy[k]              = sb_busy[k] && !fwd;
      end
    end
  end

  // Debug read sees only committed array contents.
  always_comb begin
    dbg_data = '0;
    if (ready) dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: table vectors, hand sequences for
// reset/INIT corners and a no-bypass instance, then randomized traffic
// against a behavioural model.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] rd_addr = '0;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        ready;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic [2:0]  nb_rd_addr = '0;
  logic [31:0] nb_rd_data;
  logic [0:0]  nb_rd_busy;
  logic        nb_wr_en = 1'b0;
  logic [2:0]  nb_wr_addr = '0;
  logic [31:0] nb_wr_data = '0;
  logic        nb_issue_en = 1'b0;
  logic [2:0]  nb_issue_addr = '0;
  logic        nb_ready;
  logic [2:0]  nb_dbg_addr = '0;
  logic [31:0] nb_dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .ready(ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_mp #(.XLEN(32), .NREGS(8), .NREAD(1), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(nb_rd_addr), .rd_data(nb_rd_data),
    .rd_busy(nb_rd_busy), .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
    .issue_en(nb_issue_en), .issue_addr(nb_issue_addr), .ready(nb_ready),
    .dbg_addr(nb_dbg_addr), .dbg_data(nb_dbg_data)
  );

  // Reference model of the 32-entry, 3-port, bypassing instance.
  logic [31:0] m_regs [32];
  logic        m_sb   [32];
  logic        m_ready = 1'b0;
  int          m_init  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_ready || a == 5'(REG_ZERO)) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!m_ready || a == 5'(REG_ZERO)) return 1'b0;
    return m_sb[a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic check_model(input string tag);
    logic [2:0] eb;
    eb = '0;
    chk({tag, "_ready"}, 32'(ready), 32'(m_ready));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_rd%0d", tag, k), rd_data[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5]));
      eb[k] = exp_busy(rd_addr[k*5 +: 5]);
    end
    chk({tag, "_busy"}, 32'(rd_busy), 32'(eb));
    chk({tag, "_dbg"}, dbg_data, m_ready ? m_regs[dbg_addr] : 32'h0);
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic clk_edge();
    @(posedge clock);
    if (reset) begin
      m_ready = 1'b0;
      m_init  = 0;
      for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
    end else if (!m_ready) begin
      m_init++;
      if (m_init == 32) begin
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
      end
    end else begin
      if (wr_en && wr_addr != 5'(REG_ZERO)) begin
        m_regs[wr_addr] = wr_data;
        m_sb[wr_addr]   = 1'b0;
      end
      if (issue_en && issue_addr != 5'(REG_ZERO)) m_sb[issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic cycle(input bit do_check, input string tag);
    #3;
    if (do_check) check_model(tag);
    clk_edge();
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0; wr_addr = '0; wr_data = '0; issue_addr = '0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [14:0] ra;
    logic [4:0]  da;
    logic [95:0] ed;
    logic [2:0]  eb;
    logic [31:0] edbg;
  } vec_t;

  function automatic vec_t mkv(input logic we, input int wa, input logic [31:0] wd,
                               input logic ie, input int ia,
                               input int a0, input int a1, input int a2, input int da,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [2:0] eb, input logic [31:0] edbg);
    vec_t v;
    v.we = we; v.wa = 5'(wa); v.wd = wd; v.ie = ie; v.ia = 5'(ia);
    v.ra = {5'(a2), 5'(a1), 5'(a0)}; v.da = 5'(da);
    v.ed = {d2, d1, d0}; v.eb = eb; v.edbg = edbg;
    return v;
  endfunction

  vec_t vt [13];

  initial begin
    int edges;

    vt[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0,  5, 0, 5,  5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3'b000, 0);
    vt[1]  = mkv(0, 0, 0, 0, 0,             5, 5, 0,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3'b000, 32'hDEADBEEF);
    vt[2]  = mkv(1, 0, 32'h12345678, 1, 0,  0, 0, 0,  0, 0, 0, 0, 3'b000, 0);
    vt[3]  = mkv(0, 0, 0, 1, 10,            10, 0, 5, 5, 0, 0, 32'hDEADBEEF, 3'b000, 32'hDEADBEEF);
    vt[4]  = mkv(0, 0, 0, 0, 0,             10, 10, 1, 10, 0, 0, 0, 3'b011, 0);
    vt[5]  = mkv(1, 10, 32'h55, 0, 0,       10, 1, 10, 10, 32'h55, 0, 32'h55, 3'b000, 0);
    vt[6]  = mkv(0, 0, 0, 0, 0,             10, 10, 10, 10, 32'h55, 32'h55, 32'h55, 3'b000, 32'h55);
    vt[7]  = mkv(1, 10, 32'h66, 1, 10,      10, 10, 2, 10, 32'h66, 32'h66, 0, 3'b000, 32'h55);
    vt[8]  = mkv(0, 0, 0, 0, 0,             10, 2, 1, 10, 32'h66, 0, 0, 3'b001, 32'h66);
    vt[9]  = mkv(1, 11, 32'hCAFEF00D, 0, 0, 11, 11, 11, 11, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 0);
    vt[10] = mkv(1, 1, 32'h11, 0, 0,        1, 2, 11, 11, 32'h11, 0, 32'hCAFEF00D, 3'b000, 32'hCAFEF00D);
    vt[11] = mkv(1, 2, 32'h22, 1, 1,        1, 2, 11, 2, 32'h11, 32'h22, 32'hCAFEF00D, 3'b000, 0);
    vt[12] = mkv(0, 0, 0, 0, 0,             1, 2, 11, 2, 32'h11, 32'h22, 32'hCAFEF00D, 3'b001, 32'h22);

    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_sb[i] = 1'b0; end

    // Reset for three cycles, then count edges to ready.
    reset = 1'b1;
    cycle(0, "rst");
    cycle(1, "rst");
    cycle(1, "rst");
    reset = 1'b0;
    edges = 0;
    while (!ready && edges < 100) begin
      cycle(1, "init");
      edges++;
      chk("nb_ready_init", 32'(nb_ready), 32'(edges >= 8));
    end
    chk("ready_latency", edges, 32);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      cycle(1, "dbg_sweep");
    end

    // Table vectors after ready.
    for (int i = 0; i < 13; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      issue_en = vt[i].ie; issue_addr = vt[i].ia;
      rd_addr = vt[i].ra; dbg_addr = vt[i].da;
      #3;
      for (int k = 0; k < 3; k++)
        chk($sformatf("vec%0d_rd%0d", i, k), rd_data[k*32 +: 32], vt[i].ed[k*32 +: 32]);
      chk($sformatf("vec%0d_busy", i), 32'(rd_busy), 32'(vt[i].eb));
      chk($sformatf("vec%0d_dbg", i), dbg_data, vt[i].edbg);
      clk_edge();
    end
    idle();

    // Reset partway through INIT; writes during INIT must not land.
    wr_en = 1'b1; wr_addr = 5'(REG_T2); wr_data = 32'hAAAA5555;
    cycle(1, "w7");
    idle();
    rd_addr = {3{5'(REG_T2)}};
    cycle(1, "r7");
    chk("r7_value", rd_data[31:0], 32'hAAAA5555);
    reset = 1'b1;
    cycle(1, "rst2");
    reset = 1'b0;
    repeat (10) cycle(1, "init2");
    reset = 1'b1;
    cycle(1, "rst3");
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'(REG_T2); wr_data = 32'hFFFF0000;
    issue_en = 1'b1; issue_addr = 5'(REG_T2);
    edges = 0;
    while (!ready && edges < 100) begin
      cycle(1, "init3");
      edges++;
    end
    chk("ready_latency_mid_init", edges, 32);
    idle();
    rd_addr = {3{5'(REG_T2)}}; dbg_addr = 5'(REG_T2);
    #3;
    chk("r7_after_reinit", rd_data[31:0], 32'h0);
    chk("r7_busy_after_reinit", 32'(rd_busy), 32'h0);
    chk("r7_dbg_after_reinit", dbg_data, 32'h0);
    clk_edge();

    // No-bypass, no-zero-register instance.
    chk("nb_ready", 32'(nb_ready), 32'h1);
    nb_wr_en = 1'b1; nb_wr_addr = 3'd5; nb_wr_data = 32'hDEADBEEF; nb_rd_addr = 3'd5;
    #3; chk("nb_old_value", nb_rd_data, 32'h0); clk_edge();
    nb_wr_en = 1'b0;
    #3; chk("nb_new_value", nb_rd_data, 32'hDEADBEEF); clk_edge();
    nb_wr_en = 1'b1; nb_wr_addr = 3'd0; nb_wr_data = 32'h12345678; nb_rd_addr = 3'd0;
    #3; chk("nb_r0_old", nb_rd_data, 32'h0); clk_edge();
    nb_wr_en = 1'b0;
    #3; chk("nb_r0_written", nb_rd_data, 32'h12345678); clk_edge();
    nb_issue_en = 1'b1; nb_issue_addr = 3'd3; nb_rd_addr = 3'd3;
    #3; chk("nb_busy_issue_cycle", 32'(nb_rd_busy), 32'h0); clk_edge();
    nb_issue_en = 1'b0; nb_wr_en = 1'b1; nb_wr_addr = 3'd3; nb_wr_data = 32'h77;
    #3;
    chk("nb_busy_write_cycle", 32'(nb_rd_busy), 32'h1);
    chk("nb_data_write_cycle", nb_rd_data, 32'h0);
    clk_edge();
    nb_wr_en = 1'b0; nb_dbg_addr = 3'd5;
    #3;
    chk("nb_busy_after", 32'(nb_rd_busy), 32'h0);
    chk("nb_data_after", nb_rd_data, 32'h77);
    chk("nb_dbg", nb_dbg_data, 32'hDEADBEEF);
    clk_edge();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 149) == 0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      for (int k = 0; k < 3; k++)
        rd_addr[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
      cycle(1, "rand");
    end
    reset = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core register file.
- Configurable data width, register count and number of read ports.
- Gated write port with optional write-to-read bypass.
- Per-register scoreboard of pending writes.
- Sequential clear engine that zeroes the array after reset and raises ready when done.
- Sits between decode/issue (reads, issue marks) and writeback (write port); the pipeline stalls on rd_busy or !ready.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, >= 2); AW = $clog2(NREGS)
NREAD, 2, number of combinational read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes/issues to it ignored)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clock  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
rd_addr  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NREAD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  out  NREAD  port k's register has a pending (issued, unwritten) value
wr_en  in  1  write enable
wr_addr  in  AW  write address
wr_data  in  XLEN  write data
issue_en  in  1  mark issue_addr as pending
issue_addr  in  AW  destination register of newly issued instruction
ready  out  1  clear sequence finished; block accepts writes/issues
dbg_addr  in  AW  debug read address (no bypass)
dbg_data  out  XLEN  regs[dbg_addr], 0 while not ready

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. While reset is high: state=INIT, clear counter=0, scoreboard all 0, ready=0.
- FSM has two states.
  - INIT: each cycle writes 0 to regs[counter], then counter++. When counter==NREGS-1 the write completes and next state is RUN.
  - RUN: normal operation; terminal until reset.
- ready=1 exactly NREGS cycles after the first edge with reset low.
- Reset asserted mid-INIT or in RUN returns to INIT with counter=0.
- In INIT:
  - wr_en and issue_en are ignored (no array or scoreboard update).
  - rd_data=0, rd_busy=0, dbg_data=0.
- Write (RUN): if wr_en and !(ZERO_REG && wr_addr==0), regs[wr_addr] <= wr_data at the edge. The same edge clears sb[wr_addr].
- Issue (RUN): if issue_en and !(ZERO_REG && issue_addr==0), sb[issue_addr] <= 1.
- Issue and write to the same address in one cycle: set wins, so sb stays 1 (new producer). The array is still written.
- Read port k is combinational, 0-cycle latency. Priority:
  1. ZERO_REG && addr==0 -> 0
  2. BYPASS && wr_en && wr_addr==addr (write not suppressed) -> wr_data
  3. otherwise regs[addr]
- rd_busy[k] = sb[addr] && !(BYPASS && valid write to addr this cycle). With ZERO_REG, always 0 for addr 0.
- Multiple read ports may use the same address; all return identical data.
- Without BYPASS, the read of a register written this cycle returns the old value. The new value is visible the next cycle.
- Non-power-of-two NREGS is unsupported; elaborate-time error.
- No X on outputs after ready: every entry is cleared by INIT.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF=32, NREGS_DEF=32
  - FSM state enum {ST_INIT, ST_RUN}
  - ABI index constants REG_ZERO=0, REG_RA=1, REG_SP=2, REG_T0=5, REG_T1=6, REG_T2=7, REG_A0=10, REG_A1=11, for debug/bench use
- One sub-module: regfile_scoreboard.
  - Contents: NREGS busy bits, set/clear ports with set-wins rule, synchronous clear on reset, NREAD lookup outputs.
- The array, FSM, bypass muxes and debug port stay in regfile_mp.

Test Plan:
1. Reset for 3 cycles, release. ready=0 for 32 cycles and rises on cycle 32. Then dbg_addr sweep 0..31 -> dbg_data=0 for every address.
2. After ready: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF with rd_addr0=5.
   - BYPASS=1: rd_data0=0xDEADBEEF same cycle.
   - BYPASS=0: old value 0 that cycle, 0xDEADBEEF next cycle.
3. wr_en=1, wr_addr=0, wr_data=0x12345678 (ZERO_REG=1); issue_en=1, issue_addr=0 -> rd_data for addr 0 stays 0, rd_busy stays 0, dbg_data(0)=0.
4. issue_addr=10 -> rd_busy=1 for reads of 10 from the next cycle. Write 10=0x55 -> busy drops that cycle (BYPASS=1) with rd_data=0x55, and stays 0 after. Same-cycle issue and write to 10 -> busy remains 1.
5. Write 7=0xAAAA5555, then reset for 1 cycle at INIT counter 10. ready=0 again, counter restarts, NREGS cycles to ready. Reg 7 reads 0. wr_en during INIT leaves the array unchanged.
6. NREAD=3, all ports rd_addr=11 after writing 0xCAFEF00D -> all three rd_data equal 0xCAFEF00D. Mixed addresses {1,2,11} return independent values.
